// File: rtl/klei22_ra_pkg.sv
// Shared constants and width helpers for the klei22 rolling-average tile.
// Latency: none (compile-time only).
// Backpressure: none.
package klei22_ra_pkg;

    // Output rounding modes.
    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A full window of maximum samples fits without wrapping.
    function automatic int sum_width(input int bits_per_elem, input int log2_max_win);
        return bits_per_elem + log2_max_win;
    endfunction

    // Enough bits to express every legal k in 0..log2_max_win.
    function automatic int wsel_width(input int log2_max_win);
        return clog2(log2_max_win + 1);
    endfunction

endpackage

// File: rtl/klei22_sync_rise.sv
// Two-flop synchroniser for a slow async strobe, plus a one-cycle rising-edge pulse.
// Latency: pulse is high in the cycle after the 2nd clk edge that sees din high.
// Backpressure: none; a strobe held high for any length yields exactly one pulse.
module klei22_sync_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Metastability filter (sync1, sync2) followed by a history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/klei22_ra_win.sv
// Rolling average over a run-time selectable power-of-two window of strobed samples.
// Latency: sum/fill update 2 edges after the strobe is first seen high; o_avg/o_upd 1 edge later.
// Backpressure: none; samples must respect the minimum strobe high/low times.
module klei22_ra_win
    import klei22_ra_pkg::*;
#(
    parameter int BITS_PER_ELEM = 5,
    parameter int LOG2_MAX_WIN  = 3,
    parameter int ROUND         = ROUND_TRUNC,
    parameter int WSEL_W        = wsel_width(LOG2_MAX_WIN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_data_clk,
    input  logic [BITS_PER_ELEM-1:0] i_value,
    input  logic [WSEL_W-1:0]        i_win_sel,
    output logic [BITS_PER_ELEM-1:0] o_avg,
    output logic                     o_valid,
    output logic                     o_upd
);

    localparam int DEPTH  = 1 << LOG2_MAX_WIN;
    localparam int SUM_W  = sum_width(BITS_PER_ELEM, LOG2_MAX_WIN);
    localparam int PTR_W  = LOG2_MAX_WIN;
    localparam int FILL_W = LOG2_MAX_WIN + 1;
    localparam int K_W    = wsel_width(LOG2_MAX_WIN);

    logic                     sample_ev;
    logic [K_W-1:0]           k_sel;
    logic [K_W-1:0]           k_q;
    logic                     flush;
    logic [FILL_W-1:0]        win_len;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         old_idx;
    logic [BITS_PER_ELEM-1:0] old_val;
    logic [FILL_W-1:0]        fill;
    logic [SUM_W-1:0]         sum;
    logic [SUM_W-1:0]         sum_add;
    logic [SUM_W-1:0]         sum_roll;
    logic [SUM_W:0]           rounded;
    logic [BITS_PER_ELEM-1:0] avg_next;
    logic                     upd_pend;
    logic [BITS_PER_ELEM-1:0] win_buf [DEPTH];

    klei22_sync_rise u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (i_data_clk),
        .rise (sample_ev)
    );

    // Clamp the requested window exponent to the buffer depth.
    always_comb begin
        k_sel = K_W'(i_win_sel);
        if (int'(i_win_sel) > LOG2_MAX_WIN) begin
            k_sel = K_W'(LOG2_MAX_WIN);
        end
    end

    assign flush   = (k_sel != k_q);
    assign win_len = FILL_W'(1) << k_q;
    // 2**k == DEPTH wraps to 0 in PTR_W bits, which correctly selects the oldest slot.
    assign old_idx = wr_ptr - win_len[PTR_W-1:0];
    assign old_val = win_buf[old_idx];
    assign sum_add = sum + SUM_W'(i_value);
    // Exact in modular SUM_W arithmetic because the true result is non-negative and fits.
    assign sum_roll = sum + SUM_W'(i_value) - SUM_W'(old_val);

    // Sample storage; contents are only read after being written, so no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && sample_ev) begin
            win_buf[wr_ptr] <= i_value;
        end
    end

    // Window state: exponent, write pointer, running sum and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            wr_ptr <= '0;
            sum    <= '0;
            fill   <= '0;
        end else begin
            k_q <= k_sel;
            if (sample_ev) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                // A coincident sample becomes the first entry of the new window.
                if (sample_ev) begin
                    sum  <= SUM_W'(i_value);
                    fill <= FILL_W'(1);
                end else begin
                    sum  <= '0;
                    fill <= '0;
                end
            end else if (sample_ev) begin
                if (fill == win_len) begin
                    sum <= sum_roll;
                end else begin
                    sum  <= sum_add;
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Divide by the window length, optionally adding half an LSB first.
    always_comb begin
        rounded = {1'b0, sum};
        if (ROUND == ROUND_HALF_UP && k_q != '0) begin
            rounded = {1'b0, sum} + ((SUM_W+1)'(1) << (k_q - 1'b1));
        end
        avg_next = BITS_PER_ELEM'(rounded >> k_q);
    end

    // Output stage: publish the new average the edge after a sample lands in sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_pend <= 1'b0;
            o_upd    <= 1'b0;
            o_avg    <= '0;
            o_valid  <= 1'b0;
        end else begin
            upd_pend <= sample_ev;
            o_upd    <= upd_pend;
            if (upd_pend) begin
                o_avg   <= avg_next;
                o_valid <= (fill == win_len);
            end
            if (flush) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
